// File: rtl/mem_access_unit.sv
// Load/store unit between execute and a fixed-latency data memory; one request in flight.
// Optional macro MEM_ADDR_CHECK_EN: addresses >= MEM_DEPTH fault straight to a response with resp_err=1.
module mem_access_unit #(
  parameter int RD_LAT    = 1,
  parameter int MEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

`ifdef MEM_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        addr_oob;

  assign addr_oob = ADDR_CHECK && (req_addr >= 32'(MEM_DEPTH));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    we_d       = we_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          we_d    = req_we;
          cnt_d   = 2'd0;
          rdata_d = 32'd0;
          err_d   = addr_oob;
          if (addr_oob)    state_d = RESP;
          else if (req_we) state_d = WRITE;
          else             state_d = READ;
        end
      end
      // Strobes are also qualified by the latched direction so they can never overlap.
      WRITE: begin
        mem_write = we_q;
        rdata_d   = 32'd0;
        state_d   = RESP;
      end
      READ: begin
        mem_read = ~we_q;
        if (cnt_q == LAST_CNT) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // The address/data registers double as the memory bus so it holds between accesses.
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = ADDR_CHECK & err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench: two units (RD_LAT=1 and RD_LAT=3) against a behavioural memory and a reference model.
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2], req_valid[2], req_ready[2], req_we[2];
  logic        mem_read[2], mem_write[2], resp_valid[2], resp_ready[2], resp_err[2], busy[2];
  logic [31:0] req_addr[2], req_wdata[2], mem_addr[2], mem_wdata[2], mem_rdata[2], resp_rdata[2];

  logic [31:0] mem[2][2048];
  bit          wr_ok[2][2048];
  logic [31:0] mdl[2][2048];

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MEM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  function automatic logic [31:0] pat(logic [31:0] a);
    return a * 32'd3 + 32'd17;
  endfunction

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : gd
      mem_access_unit #(.RD_LAT((g == 0) ? 1 : 3), .MEM_DEPTH(1024)) dut (
        .clk(clk), .rst(rst[g]),
        .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
        .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
        .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
        .mem_read(mem_read[g]), .mem_write(mem_write[g]), .mem_rdata(mem_rdata[g]),
        .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]),
        .resp_rdata(resp_rdata[g]), .resp_err(resp_err[g]), .busy(busy[g])
      );
      assign mem_rdata[g] = mem_read[g] ?
        (wr_ok[g][mem_addr[g][10:0]] ? mem[g][mem_addr[g][10:0]] : pat(mem_addr[g])) : ~mem_addr[g];
      always @(posedge clk) begin
        if (mem_write[g]) begin
          mem[g][mem_addr[g][10:0]]   <= mem_wdata[g];
          wr_ok[g][mem_addr[g][10:0]] <= 1'b1;
        end
      end
    end
  endgenerate

  typedef struct {
    int          d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          hold;
    bit          noise;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    int          lat;
    int          strobes;
  } exp_t;

  exp_t sb[$];
  vec_t tv[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int   d, cyc, lat, nstb;
    bit   got;
    exp_t e, x;
    d         = v.d;
    e.err     = CHK && (v.addr >= 32'd1024);
    e.rdata   = (v.we || e.err) ? 32'd0 : mdl[d][v.addr[10:0]];
    e.lat     = e.err ? 1 : (v.we ? 2 : lat_of(d) + 1);
    e.strobes = e.err ? 0 : (v.we ? 1 : lat_of(d));
    if (v.we && !e.err) mdl[d][v.addr[10:0]] = v.wdata;

    cyc = 0;
    while (!req_ready[d] && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk1("req_ready_idle", req_ready[d], 1'b1);
    req_valid[d] = 1'b1;
    req_we[d]    = v.we;
    req_addr[d]  = v.addr;
    req_wdata[d] = v.wdata;
    sb.push_back(e);
    @(posedge clk);

    nstb = 0;
    got  = 1'b0;
    lat  = -1;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (v.noise) begin
        req_valid[d] = 1'b1;
        req_we[d]    = ~v.we;
        req_addr[d]  = v.addr + 32'd77;
        req_wdata[d] = ~v.wdata;
      end else begin
        req_valid[d] = 1'b0;
      end
      chk1("strobe_excl", mem_read[d] & mem_write[d], 1'b0);
      if (mem_read[d] || mem_write[d]) begin
        nstb++;
        chk("strobe_addr", mem_addr[d], v.addr);
        chk1("strobe_dir", mem_write[d], v.we);
        if (mem_write[d]) chk("strobe_wdata", mem_wdata[d], v.wdata);
      end
      if (resp_valid[d]) begin
        got = 1'b1;
        lat = c;
      end
    end
    req_valid[d] = 1'b0;
    chk1("resp_arrived", got, 1'b1);

    if (sb.size() == 0) begin
      chk1("sb_nonempty", 1'b0, 1'b1);
    end else begin
      x = sb.pop_front();
      chk("latency", 32'(lat), 32'(x.lat));
      chk("strobe_count", 32'(nstb), 32'(x.strobes));
      chk("resp_rdata", resp_rdata[d], x.rdata);
      chk1("resp_err", resp_err[d], x.err);
      for (int h = 0; h < v.hold; h++) begin
        @(negedge clk);
        chk1("hold_valid", resp_valid[d], 1'b1);
        chk("hold_rdata", resp_rdata[d], x.rdata);
        chk1("hold_err", resp_err[d], x.err);
        chk1("hold_req_ready", req_ready[d], 1'b0);
        chk1("hold_busy", busy[d], 1'b1);
      end
    end

    resp_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready[d] = 1'b0;
    chk1("post_req_ready", req_ready[d], 1'b1);
    chk1("post_resp_valid", resp_valid[d], 1'b0);
    chk1("post_busy", busy[d], 1'b0);
    chk1("post_strobes", mem_read[d] | mem_write[d], 1'b0);
    chk("post_mem_addr", mem_addr[d], v.addr);
    chk("post_mem_wdata", mem_wdata[d], v.wdata);
  endtask

  initial begin
    bit seen;
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 2048; a++) mdl[d][a] = pat(32'(a));
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;  req_valid[d] = 1'b0; req_we[d] = 1'b0;
      req_addr[d] = 32'd0; req_wdata[d] = 32'd0; resp_ready[d] = 1'b1;
    end
    // Request and response handshake held active during reset must be ignored.
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'd3; req_wdata[0] = 32'd9;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk1("rst_req_ready", req_ready[d], 1'b1);
      chk1("rst_busy", busy[d], 1'b0);
      chk1("rst_mem_read", mem_read[d], 1'b0);
      chk1("rst_mem_write", mem_write[d], 1'b0);
      chk1("rst_resp_valid", resp_valid[d], 1'b0);
      chk1("rst_resp_err", resp_err[d], 1'b0);
      chk("rst_resp_rdata", resp_rdata[d], 32'd0);
      chk("rst_mem_addr", mem_addr[d], 32'd0);
      chk("rst_mem_wdata", mem_wdata[d], 32'd0);
      rst[d] = 1'b0; req_valid[d] = 1'b0; resp_ready[d] = 1'b0;
    end

    tv[0]  = '{0, 1'b1, 32'd1,    32'd69,         0, 1'b0};
    tv[1]  = '{0, 1'b0, 32'd1,    32'h0000_0101,  0, 1'b0};
    tv[2]  = '{1, 1'b1, 32'd5,    32'hA5A5_0005,  0, 1'b0};
    tv[3]  = '{1, 1'b0, 32'd5,    32'h0000_1111,  0, 1'b1};
    tv[4]  = '{1, 1'b0, 32'd5,    32'h0000_2222,  5, 1'b0};
    tv[5]  = '{0, 1'b1, 32'd1023, 32'hFFFF_FFFF,  1, 1'b0};
    tv[6]  = '{0, 1'b0, 32'd1023, 32'h0000_3333,  0, 1'b0};
    tv[7]  = '{0, 1'b1, 32'd1024, 32'h0000_1234,  2, 1'b0};
    tv[8]  = '{0, 1'b0, 32'd1024, 32'h0000_4444,  0, 1'b0};
    tv[9]  = '{1, 1'b0, 32'd7,    32'h0000_5555,  0, 1'b1};
    tv[10] = '{1, 1'b1, 32'd1024, 32'hCAFE_F00D,  0, 1'b0};
    for (int i = 0; i < 11; i++) run_txn(tv[i]);

    // Reset during the second READ cycle of the RD_LAT=3 unit.
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'd5; req_wdata[1] = 32'd0;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk1("abort_rd1", mem_read[1], 1'b1);
    @(negedge clk);
    chk1("abort_rd2", mem_read[1], 1'b1);
    rst[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    chk1("abort_mem_read", mem_read[1], 1'b0);
    chk1("abort_resp_valid", resp_valid[1], 1'b0);
    chk1("abort_req_ready", req_ready[1], 1'b1);
    chk1("abort_busy", busy[1], 1'b0);
    chk("abort_mem_addr", mem_addr[1], 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid[1] || mem_read[1]) seen = 1'b1;
    end
    chk1("abort_no_resp", seen, 1'b0);

    run_txn('{1, 1'b0, 32'd5, 32'h0000_6666, 0, 1'b0});
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter RD_LAT, default 1, data-memory read latency in cycles (legal 1..4).
REQ-002 SHALL have parameter MEM_DEPTH, default 1024, data-memory size in 32-bit words.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk and rst, as named below.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req_valid  input  1  request from execute stage.
REQ-007 req_ready  output  1  unit can accept a request.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  word address.
REQ-010 req_wdata  input  32  store data.
REQ-011 mem_addr  output  32  address to data memory.
REQ-012 mem_wdata  output  32  write data to data memory.
REQ-013 mem_read  output  1  data-memory MemRead.
REQ-014 mem_write  output  1  data-memory MemWrite.
REQ-015 mem_rdata  input  32  read data from data memory.
REQ-016 resp_valid  output  1  response available for writeback.
REQ-017 resp_ready  input  1  writeback accepts response.
REQ-018 resp_rdata  output  32  load result; 0 for stores.
REQ-019 resp_err  output  1  address fault flag.
REQ-020 busy  output  1  high in any state other than IDLE.

Function
REQ-021 SHALL implement FSM states IDLE, WRITE, READ, RESP.
REQ-022 IDLE: req_ready=1; on req_valid, latch req_addr, req_wdata, req_we into registers; store -> WRITE, load -> READ.
REQ-023 req_ready SHALL be 0 in every state except IDLE; request inputs SHALL be ignored outside IDLE.
REQ-024 WRITE: mem_write=1 for exactly one cycle, mem_addr/mem_wdata = latched values; next -> RESP with resp_rdata=0.
REQ-025 READ: mem_read=1 for exactly RD_LAT consecutive cycles, mem_addr = latched address; a 2-bit counter tracks the cycles.
REQ-026 READ: mem_rdata SHALL be captured into resp_rdata at the rising edge ending the last READ cycle; next -> RESP.
REQ-027 RESP: resp_valid=1, resp_rdata and resp_err held stable until resp_ready=1; the edge with resp_ready=1 -> IDLE.
REQ-028 Latency, accept edge to first resp_valid cycle: store 2 cycles, load RD_LAT+1 cycles.
REQ-029 mem_read and mem_write SHALL never be high in the same cycle, and both SHALL be 0 outside READ/WRITE.
REQ-030 Outside READ/WRITE, mem_addr and mem_wdata SHALL hold the last latched values.
REQ-031 New request SHALL be accepted no earlier than the cycle after the RESP handshake (single outstanding request).

Reset
REQ-032 rst SHALL force IDLE; req_ready=1; mem_read=0, mem_write=0, resp_valid=0, resp_err=0, busy=0; resp_rdata, mem_addr and mem_wdata = 0.
REQ-033 rst asserted in WRITE/READ SHALL abort the access: no strobe in the cycle after the reset edge, no response is produced.
REQ-034 rst SHALL take priority over req_valid and resp_ready in the same cycle.

Configuration
REQ-035 Macro MEM_ADDR_CHECK_EN defined: an accepted request with address >= MEM_DEPTH SHALL skip WRITE/READ, assert no strobe, and go directly to RESP with resp_err=1, resp_rdata=0, 1-cycle latency.
REQ-036 Macro MEM_ADDR_CHECK_EN undefined: resp_err SHALL be tied to 0, and every address goes to memory unchanged.

Verification
REQ-037 Store addr=1, wdata=69, RD_LAT=1 -> mem_write=1 one cycle with mem_addr=1, mem_wdata=69; resp_valid 2 cycles after accept; resp_rdata=0.
REQ-038 Load addr=1 after REQ-037, memory returns 69 -> mem_read=1 one cycle; resp_rdata=69 at cycle 2; resp_err=0.
REQ-039 RD_LAT=3, load addr=5 -> mem_read high 3 cycles; resp_valid at cycle 4; req_valid pulses during READ ignored.
REQ-040 resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stable; req_ready=0 until the cycle after handshake.
REQ-041 rst in 2nd READ cycle (RD_LAT=3) -> next cycle IDLE, mem_read=0, resp_valid=0, req_ready=1.
REQ-042 With MEM_ADDR_CHECK_EN, store addr=1024 -> no mem_write; resp_valid next cycle with resp_err=1; without the macro -> normal store to 1024, resp_err=0.
